// File: rtl/spike_pkg.sv
// Shared types and saturating arithmetic for the delta-modulation spike scheduler.
// Each threshold moves by at most delta per sample and is clamped at the ends of its range.
package spike_pkg;

   typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_e;
   typedef enum logic {SPK_DOWN = 1'b0, SPK_UP = 1'b1} spk_pol_e;

   localparam int SPK_CH_W = 4;
   localparam int MAX_DW   = 64;

   typedef struct packed {
      logic [SPK_CH_W-1:0] ch;
      spk_pol_e            pol;
   } spk_evt_t;

   // Operands are zero-extended DW-bit values; the result clips at 2^dw-1.
   function automatic logic [MAX_DW-1:0] sat_add(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] b,
                                                 input int dw);
      logic [MAX_DW:0] sum;
      logic [MAX_DW:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ((MAX_DW+1)'(1) << dw) - (MAX_DW+1)'(1);
      return (sum > lim) ? lim[MAX_DW-1:0] : sum[MAX_DW-1:0];
   endfunction

   // The borrow out of the extra bit means the result went below zero.
   function automatic logic [MAX_DW-1:0] sat_sub(input logic [MAX_DW-1:0] a,
                                                 input logic [MAX_DW-1:0] b);
      logic [MAX_DW:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      return diff[MAX_DW] ? '0 : diff[MAX_DW-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: the first requester at or after the pointer wins.
// The pointer moves only when the owner reports that the grant was consumed.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CW     = $clog2(NUM_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_adv,
   input  logic [CW-1:0]     i_adv_idx,
   output logic [CW-1:0]     o_gnt,
   output logic              o_gnt_vld
);

   logic [CW-1:0] r_ptr;

   // Scan from the far end so that the lowest offset from the pointer is assigned last.
   always_comb begin
      int w_idx;
      o_gnt     = '0;
      o_gnt_vld = 1'b0;
      w_idx     = 0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         if (i_req[w_idx]) begin
            o_gnt     = CW'(w_idx);
            o_gnt_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (i_adv)
         r_ptr <= (i_adv_idx == CW'(NUM_CH-1)) ? '0 : i_adv_idx + 1'b1;
   end

endmodule

// File: rtl/spike_enc_sched.sv
// Multi-channel delta-modulation spike scheduler.
// Channels share one threshold compare/update unit, and the resulting spike events are streamed out.
module spike_enc_sched
   import spike_pkg::*;
#(
   parameter int             NUM_CH       = 4,
   parameter int             DW           = 32,
   parameter logic [DW-1:0]  DEFAULT_UTHR = DW'(70),
   parameter logic [DW-1:0]  DEFAULT_LTHR = DW'(10),
   parameter int             CW           = $clog2(NUM_CH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_CH-1:0]    req_i,
   input  logic [NUM_CH*DW-1:0] ecg_i,
   output logic [NUM_CH-1:0]    ack_o,
   input  logic [DW-1:0]        delta_i,
   input  logic                 cfg_we_i,
   input  logic [CW-1:0]        cfg_ch_i,
   input  logic [DW-1:0]        cfg_uthr_i,
   input  logic [DW-1:0]        cfg_lthr_i,
   output logic                 cfg_err_o,
   output logic                 spk_valid_o,
   input  logic                 spk_ready_i,
   output logic [CW-1:0]        spk_ch_o,
   output logic                 spk_up_o
);

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_gnt;
   logic [DW-1:0] r_uthr [NUM_CH];
   logic [DW-1:0] r_lthr [NUM_CH];
   spk_evt_t      r_spk;

   logic          r_pend_vld;
   logic [CW-1:0] r_pend_ch;
   logic [DW-1:0] r_pend_u, r_pend_l;

   logic [CW-1:0] w_arb_gnt;
   logic          w_arb_vld;
   logic [DW-1:0] w_sample, w_cur_u, w_cur_l;
   logic          w_hit_up, w_hit_dn, w_cfg_bad, w_cfg_ok;
   logic          w_take, w_adv, w_spk_ld, w_pend_clr, w_thr_we;
   spk_pol_e      w_spk_pol;
   logic [CW-1:0] w_thr_ch;
   logic [DW-1:0] w_thr_u, w_thr_l;
   logic          w_unused_spk;

   rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
      .i_clk     (clk_i),
      .i_rst_n   (rst_ni),
      .i_req     (req_i),
      .i_adv     (w_adv),
      .i_adv_idx (r_gnt),
      .o_gnt     (w_arb_gnt),
      .o_gnt_vld (w_arb_vld)
   );

   assign w_sample  = ecg_i[int'(r_gnt)*DW +: DW];
   assign w_cur_u   = r_uthr[r_gnt];
   assign w_cur_l   = r_lthr[r_gnt];
   assign w_hit_up  = (w_sample >= w_cur_u);
   assign w_hit_dn  = (w_sample <= w_cur_l);
   assign w_cfg_bad = cfg_we_i && ((cfg_lthr_i > cfg_uthr_i) || (int'(cfg_ch_i) >= NUM_CH));
   assign w_cfg_ok  = cfg_we_i && !w_cfg_bad;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_adv       = 1'b0;
      w_spk_ld    = 1'b0;
      w_spk_pol   = SPK_DOWN;
      w_pend_clr  = 1'b0;
      w_thr_we    = 1'b0;
      w_thr_ch    = r_gnt;
      w_thr_u     = w_cur_u;
      w_thr_l     = w_cur_l;
      case (r_state)
         IDLE: begin
            // Configuration owns the cycle; a fresh valid write supersedes a pending one.
            if (cfg_we_i || r_pend_vld) begin
               w_pend_clr = 1'b1;
               if (w_cfg_ok) begin
                  w_thr_we = 1'b1;
                  w_thr_ch = cfg_ch_i;
                  w_thr_u  = cfg_uthr_i;
                  w_thr_l  = cfg_lthr_i;
               end else if (r_pend_vld) begin
                  w_thr_we = 1'b1;
                  w_thr_ch = r_pend_ch;
                  w_thr_u  = r_pend_u;
                  w_thr_l  = r_pend_l;
               end
            end else if (w_arb_vld) begin
               w_take      = 1'b1;
               w_state_nxt = EVAL;
            end
         end
         EVAL: begin
            w_adv       = 1'b1;
            w_state_nxt = IDLE;
            if (w_hit_up) begin
               w_thr_we    = 1'b1;
               w_thr_u     = DW'(sat_add(MAX_DW'(w_cur_u), MAX_DW'(delta_i), DW));
               w_thr_l     = DW'(sat_add(MAX_DW'(w_cur_l), MAX_DW'(delta_i), DW));
               w_spk_ld    = 1'b1;
               w_spk_pol   = SPK_UP;
               w_state_nxt = EMIT;
            end else if (w_hit_dn) begin
               w_thr_we    = 1'b1;
               w_thr_u     = DW'(sat_sub(MAX_DW'(w_cur_u), MAX_DW'(delta_i)));
               w_thr_l     = DW'(sat_sub(MAX_DW'(w_cur_l), MAX_DW'(delta_i)));
               w_spk_ld    = 1'b1;
               w_state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (spk_ready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_uthr[c] <= DEFAULT_UTHR;
            r_lthr[c] <= DEFAULT_LTHR;
         end
      end else if (w_thr_we) begin
         r_uthr[w_thr_ch] <= w_thr_u;
         r_lthr[w_thr_ch] <= w_thr_l;
      end
   end

   // Writes that arrive while a sample is in flight wait here for the next IDLE cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend_vld <= 1'b0;
         r_pend_ch  <= '0;
         r_pend_u   <= '0;
         r_pend_l   <= '0;
      end else if (r_state != IDLE && w_cfg_ok) begin
         r_pend_vld <= 1'b1;
         r_pend_ch  <= cfg_ch_i;
         r_pend_u   <= cfg_uthr_i;
         r_pend_l   <= cfg_lthr_i;
      end else if (w_pend_clr) begin
         r_pend_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_gnt <= '0;
         r_spk <= '0;
      end else begin
         if (w_take)   r_gnt <= w_arb_gnt;
         if (w_spk_ld) r_spk <= '{ch: SPK_CH_W'(r_gnt), pol: w_spk_pol};
      end
   end

   assign ack_o        = (r_state == EVAL) ? (NUM_CH'(1) << r_gnt) : '0;
   assign cfg_err_o    = w_cfg_bad;
   assign spk_valid_o  = (r_state == EMIT);
   assign spk_ch_o     = r_spk.ch[CW-1:0];
   assign spk_up_o     = (r_spk.pol == SPK_UP);
   assign w_unused_spk = &{1'b0, r_spk.ch};

endmodule

// File: tb/tb_spike_enc_sched.sv
// Randomised and directed bench for spike_enc_sched; the expected output of every cycle
// comes from a transaction-level model of grants, threshold updates and spike handshakes.
module tb_spike_enc_sched;
   localparam int NUM_CH = 4;
   localparam int DW     = 32;
   localparam int CW     = 2;
   localparam longint unsigned MAXV = 64'hFFFF_FFFF;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic [NUM_CH-1:0]    req_i;
   logic [NUM_CH*DW-1:0] ecg_i;
   logic [NUM_CH-1:0]    ack_o;
   logic [DW-1:0]        delta_i;
   logic                 cfg_we_i;
   logic [CW-1:0]        cfg_ch_i;
   logic [DW-1:0]        cfg_uthr_i, cfg_lthr_i;
   logic                 cfg_err_o, spk_valid_o, spk_ready_i, spk_up_o;
   logic [CW-1:0]        spk_ch_o;

   spike_enc_sched #(.NUM_CH(NUM_CH), .DW(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ecg_i(ecg_i), .ack_o(ack_o),
      .delta_i(delta_i), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_uthr_i(cfg_uthr_i),
      .cfg_lthr_i(cfg_lthr_i), .cfg_err_o(cfg_err_o), .spk_valid_o(spk_valid_o),
      .spk_ready_i(spk_ready_i), .spk_ch_o(spk_ch_o), .spk_up_o(spk_up_o)
   );

   always #5 clk_i = ~clk_i;

   // stimulus state
   logic [NUM_CH-1:0] req_v;
   logic [DW-1:0]     ecg_v [NUM_CH];
   logic [DW-1:0]     d_delta, d_u, d_l;
   logic [CW-1:0]     d_ch;
   logic              d_we, d_ready;
   bit                hold_req;

   // model state
   longint unsigned m_u [NUM_CH];
   longint unsigned m_l [NUM_CH];
   int  m_ptr, ack_due, ack_ch, spk_ch, cyc;
   bit  spk_act, spk_up;
   bit  pend_v;
   int  pend_ch;
   longint unsigned pend_u, pend_l;

   int  n_chk, n_fail;
   logic [NUM_CH-1:0] last_ack;
   logic last_vld, last_up, last_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick();
      for (int k = 0; k < NUM_CH; k++)
         if (req_v[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
      return -1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin m_u[c] = 70; m_l[c] = 10; end
      m_ptr = 0; ack_due = -1; spk_act = 0; pend_v = 0;
   endtask

   task automatic step();
      logic [NUM_CH-1:0] exp_ack;
      bit idle, ok;
      longint unsigned s, d;
      @(negedge clk_i);
      cyc++;
      exp_ack = '0;
      if (ack_due == cyc) exp_ack[ack_ch] = 1'b1;
      chk("ack_o", ack_o, exp_ack);
      chk("spk_valid_o", spk_valid_o, spk_act);
      if (spk_act) begin
         chk("spk_ch_o", spk_ch_o, spk_ch);
         chk("spk_up_o", spk_up_o, spk_up);
      end
      last_ack = ack_o; last_vld = spk_valid_o; last_up = spk_up_o;
      if (ack_due == cyc && !hold_req) req_v[ack_ch] = 1'b0;
      req_i = req_v;
      for (int c = 0; c < NUM_CH; c++) ecg_i[c*DW +: DW] = ecg_v[c];
      delta_i = d_delta; spk_ready_i = d_ready;
      cfg_we_i = d_we; cfg_ch_i = d_ch; cfg_uthr_i = d_u; cfg_lthr_i = d_l;
      #1;
      ok = d_we && (d_l <= d_u) && (int'(d_ch) < NUM_CH);
      chk("cfg_err_o", cfg_err_o, d_we && !ok);
      last_err = cfg_err_o;
      // what the next clock edge does, from the channel-level rules
      idle = (ack_due != cyc) && !spk_act;
      if (ack_due == cyc) begin
         s = ecg_v[ack_ch]; d = d_delta;
         if (s >= m_u[ack_ch]) begin
            m_u[ack_ch] = (m_u[ack_ch] + d > MAXV) ? MAXV : m_u[ack_ch] + d;
            m_l[ack_ch] = (m_l[ack_ch] + d > MAXV) ? MAXV : m_l[ack_ch] + d;
            spk_act = 1; spk_up = 1; spk_ch = ack_ch;
         end else if (s <= m_l[ack_ch]) begin
            m_u[ack_ch] = (m_u[ack_ch] < d) ? 0 : m_u[ack_ch] - d;
            m_l[ack_ch] = (m_l[ack_ch] < d) ? 0 : m_l[ack_ch] - d;
            spk_act = 1; spk_up = 0; spk_ch = ack_ch;
         end
         m_ptr = (ack_ch + 1) % NUM_CH;
      end else if (spk_act) begin
         if (d_ready) spk_act = 0;
      end else if (d_we || pend_v) begin
         if (ok) begin m_u[d_ch] = d_u; m_l[d_ch] = d_l; end
         else if (pend_v) begin m_u[pend_ch] = pend_u; m_l[pend_ch] = pend_l; end
         pend_v = 0;
      end else if (req_v != '0) begin
         ack_ch = rr_pick(); ack_due = cyc + 1;
      end
      if (!idle && ok) begin pend_v = 1; pend_ch = d_ch; pend_u = d_u; pend_l = d_l; end
      d_we = 1'b0;
   endtask

   task automatic cfg(input int ch, input longint unsigned u, input longint unsigned l);
      d_we = 1'b1; d_ch = CW'(ch); d_u = DW'(u); d_l = DW'(l);
   endtask

   int ord[$];
   int acyc[$];
   int nv, hs;

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; hold_req = 0;
      req_v = '0; d_delta = '0; d_we = 0; d_ch = '0; d_u = '0; d_l = '0; d_ready = 1;
      for (int c = 0; c < NUM_CH; c++) ecg_v[c] = '0;
      rst_ni = 1'b0; req_i = '0; ecg_i = '0; delta_i = '0; cfg_we_i = 0;
      cfg_ch_i = '0; cfg_uthr_i = '0; cfg_lthr_i = '0; spk_ready_i = 1;
      model_reset();
      #2;
      chk("rst_ack", ack_o, 0); chk("rst_vld", spk_valid_o, 0);
      chk("rst_ch", spk_ch_o, 0); chk("rst_up", spk_up_o, 0); chk("rst_err", cfg_err_o, 0);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;

      // round-robin fairness, no spikes
      hold_req = 1; req_v = 4'b1111; d_delta = 5;
      for (int c = 0; c < NUM_CH; c++) ecg_v[c] = 40;
      for (int i = 0; i < 10; i++) begin
         step();
         for (int c = 0; c < NUM_CH; c++) if (last_ack[c]) begin ord.push_back(c); acyc.push_back(cyc); end
      end
      hold_req = 0; req_v = '0;
      chk("rr_count", ord.size(), 5);
      for (int i = 0; i < ord.size() && i < 5; i++) chk("rr_order", ord[i], i % NUM_CH);
      for (int i = 1; i < acyc.size(); i++) chk("rr_spacing", acyc[i] - acyc[i-1], 2);

      // single channel UP then DOWN
      ecg_v[0] = 80; req_v = 4'b0001;
      step(); step(); chk("t1_ack", last_ack, 4'b0001);
      step(); chk("t1_vld", last_vld, 1); chk("t1_up", last_up, 1);
      chk("t1_uthr", m_u[0], 75); chk("t1_lthr", m_l[0], 15);
      ecg_v[0] = 12; req_v = 4'b0001;
      step(); step(); step(); chk("t2_up", last_up, 0);
      chk("t2_uthr", m_u[0], 70); chk("t2_lthr", m_l[0], 10);

      // back-pressure
      ecg_v[3] = 200; ecg_v[1] = 40; d_ready = 0; req_v = 4'b1000;
      step(); step();
      req_v[1] = 1'b1; nv = 0;
      for (int i = 0; i < 5; i++) begin step(); nv += int'(last_vld); end
      d_ready = 1; step(); nv += int'(last_vld);
      chk("bp_valid_cycles", nv, 6);
      step(); chk("bp_no_ack", last_ack, 0);
      step(); chk("bp_next_ack", last_ack, 4'b0010);
      step();

      // saturation high
      cfg(1, MAXV - 2, MAXV - 9); step();
      d_delta = 8; ecg_v[1] = DW'(MAXV); req_v = 4'b0010;
      step(); step(); step(); chk("sat_hi_up", last_up, 1);
      chk("sat_hi_u", m_u[1], MAXV); chk("sat_hi_l", m_l[1], MAXV - 1);
      ecg_v[1] = DW'(MAXV - 1); req_v = 4'b0010;
      step(); step(); step();
      // saturation low
      cfg(2, 20, 3); step();
      ecg_v[2] = 0; req_v = 4'b0100;
      step(); step(); step(); chk("sat_lo_dn", last_up, 0);
      chk("sat_lo_u", m_u[2], 12); chk("sat_lo_l", m_l[2], 0);
      ecg_v[2] = 12; req_v = 4'b0100;
      step(); step(); step();

      // rejected write
      cfg(0, 40, 50); step(); chk("cfg_rej_err", last_err, 1);
      ecg_v[0] = 45; req_v = 4'b0001;
      step(); step(); step(); chk("cfg_rej_nospk", last_vld, 0);

      // write during EMIT is deferred
      ecg_v[0] = 200; req_v = 4'b0001; d_ready = 0;
      step(); step(); step();
      cfg(2, 100, 50); ecg_v[1] = 40; req_v[1] = 1'b1;
      step();
      d_ready = 1; step(); hs = cyc;
      step(); chk("pend_no_grant", last_ack, 0);
      step(); chk("pend_no_ack_yet", last_ack, 0);
      step(); chk("pend_ack", last_ack, 4'b0010); chk("pend_lat", cyc - hs, 3);
      chk("pend_u", m_u[2], 100);
      ecg_v[2] = 100; req_v = 4'b0100;
      step(); step(); step();

      // async reset while stalled in EMIT
      ecg_v[3] = 250; req_v = 4'b1000; d_ready = 0;
      step(); step(); step(); chk("rst_pre_vld", last_vld, 1);
      #2 rst_ni = 1'b0;
      #1 chk("rst_mid_vld", spk_valid_o, 0); chk("rst_mid_ack", ack_o, 0);
      chk("rst_mid_ch", spk_ch_o, 0); chk("rst_mid_up", spk_up_o, 0);
      model_reset();
      req_v = '0; req_i = '0; cfg_we_i = 0; d_ready = 1;
      @(negedge clk_i); rst_ni = 1'b1;
      for (int c = 0; c < NUM_CH; c++) ecg_v[c] = 70;
      req_v = 4'b1111;
      step(); step(); chk("post_rst_ack", last_ack, 4'b0001);
      step(); chk("post_rst_up", last_up, 1);
      repeat (12) step();

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NUM_CH; c++)
            if (!req_v[c] && $urandom_range(0, 3) == 0) begin
               req_v[c] = 1'b1; ecg_v[c] = DW'($urandom_range(0, 150));
            end
         d_delta = DW'($urandom_range(0, 10));
         d_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0)
            cfg($urandom_range(0, NUM_CH-1), $urandom_range(0, 120), $urandom_range(0, 120));
         step();
      end
      req_v = '0; d_ready = 1;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spike_enc_sched.md
Name: spike_enc_sched

Overview:
- Multi-channel scheduler and configurator for the delta-modulation spike encoding datapath.
- Holds per-channel upper/lower thresholds and arbitrates NUM_CH sample requesters round-robin onto one shared compare/update unit.
- Emits spike events (channel, polarity) on a valid/ready stream to the SNN input layer.
- Sits between the per-lead ECG sample front-ends and the network core.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
DW, 32, sample/threshold width, unsigned
DEFAULT_UTHR, 70, reset upper threshold, all channels
DEFAULT_LTHR, 10, reset lower threshold, all channels

Ports:
clk_i  in  1  single clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_CH  per-channel sample-valid; held until acked
ecg_i  in  NUM_CH*DW  per-channel samples, channel c at [c*DW +: DW]
ack_o  out  NUM_CH  one-hot, 1-cycle pulse: sample consumed
delta_i  in  DW  global threshold step, sampled in EVAL
cfg_we_i  in  1  threshold write strobe
cfg_ch_i  in  $clog2(NUM_CH)  write target channel
cfg_uthr_i  in  DW  new upper threshold
cfg_lthr_i  in  DW  new lower threshold
cfg_err_o  out  1  1-cycle pulse: write rejected
spk_valid_o  out  1  spike event valid
spk_ready_i  in  1  downstream accept
spk_ch_o  out  $clog2(NUM_CH)  spiking channel
spk_up_o  out  1  1 = UP spike, 0 = DOWN spike

Behaviour:
- Reset (async assert, sync release): all thresholds set to defaults; state IDLE; RR pointer gives channel 0 highest priority; ack_o, cfg_err_o, spk_valid_o, spk_ch_o and spk_up_o all 0.
- FSM states are IDLE, EVAL and EMIT.
- IDLE:
  - If cfg_we_i is high: perform the config write; no grant this cycle (config has priority).
  - Else if any req_i is high: grant the first requester at or after the RR pointer (wrapping), latch the channel id and go to EVAL.
- EVAL (1 cycle):
  - Pulse ack_o[g] and read s = ecg_i[g].
  - If s >= uthr[g]: UP spike; uthr += delta and lthr += delta.
  - Else if s <= lthr[g]: DOWN spike; uthr -= delta and lthr -= delta.
  - Else: no spike, thresholds unchanged.
  - UP takes precedence if both comparisons are true (only possible when uthr == lthr).
  - RR pointer moves to g+1 (wrap to 0).
  - On a spike: load the spike register and go to EMIT. Otherwise return to IDLE.
- EMIT:
  - spk_valid_o is high and spk_ch_o/spk_up_o are held stable until spk_ready_i is sampled high. Then deassert and return to IDLE.
  - No new grant while in EMIT; requesters back-pressure through req_i held.
- Latency:
  - req_i rising in IDLE at cycle N: ack_o at N+1, spk_valid_o at N+2.
  - Best throughput is one sample per 2 cycles when spk_ready_i is tied high.
- Arithmetic: unsigned DW-bit, computed DW+1 wide and saturated. Add clips at 2^DW-1; subtract clips at 0. Saturation is applied to each threshold independently.
- Config rules:
  - A write is accepted only if cfg_lthr_i <= cfg_uthr_i. Otherwise cfg_err_o pulses in the same cycle and the thresholds are unchanged.
  - cfg_we_i arriving in EVAL or EMIT is not dropped: it is held in a 1-entry pending register and applied on the next IDLE cycle, before any grant.
  - A second write arriving while one is pending overwrites the pending one.
- Reset mid-operation: everything returns to reset values immediately. An in-flight spike is lost, and no ack is issued for a sample already latched.
- cfg_ch_i >= NUM_CH: the write is rejected and cfg_err_o pulses.

Decomposition:
- Shared package spike_pkg holds:
  - state_e {IDLE, EVAL, EMIT}
  - spk_pol_e {SPK_DOWN, SPK_UP}
  - spk_evt_t struct {ch, pol}
  - saturating add/sub functions, parameterised on DW
- One sub-module, rr_arbiter: NUM_CH requests in; grant index and valid out; pointer-advance input.
- Threshold storage is flops (no RAM), so the EVAL read is combinational.

Test Plan:
- Reset defaults, single channel:
  - ch0 sample 80, delta 5 -> ack_o=0001 one cycle after req; UP spike on ch0; ch0 thresholds become 75/15.
  - ch0 sample 12 -> DOWN spike; thresholds become 70/10.
- Round-robin fairness: req_i=1111 held high, all samples 40 (no spikes) -> ack order 0,1,2,3,0, one ack every 2 cycles, no spk_valid_o.
- Back-pressure: UP spike with spk_ready_i held low for 5 cycles -> spk_valid_o, ch and pol stable for 6 cycles; no ack_o during the stall; next grant on the cycle after the handshake.
- Saturation:
  - Config ch1 = (2^32-3)/(2^32-10), delta 8, sample 2^32-1 -> UP spike; uthr=2^32-1, lthr=2^32-2.
  - Config ch2 = 20/3, delta 8, sample 0 -> DOWN spike; lthr=0, uthr=12.
- Config rules:
  - Write lthr=50, uthr=40 -> cfg_err_o pulse; thresholds unchanged.
  - Write during EMIT -> applied in the next IDLE; a same-cycle pending req is granted one cycle later.
- Async reset asserted in EMIT -> spk_valid_o drops immediately; thresholds return to 70/10; the next grant goes to ch0.
